// File: rtl/spi_mode0.sv
// SPI mode-0 master: shifts one byte out on mosi (MSB first) while sampling miso,
// then holds busy through a programmable inter-byte gap before returning to idle.
module spi_mode0 #(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       get_byte,
    input  logic [7:0] data_send,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic [7:0] data_rx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_div;
    logic [2:0]  r_bit;
    logic [15:0] r_gap;
    logic [6:0]  r_tx;
    logic [7:0]  r_rx;
    logic [7:0]  r_data_rx;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_busy;

    logic w_tc;
    logic w_start;
    logic w_rise;
    logic w_fall;
    logic w_last;
    logic w_gap_done;

    always_comb begin
        w_state_nxt = r_state;
        w_tc        = (r_div == DIV_LAST);
        w_start     = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_last      = 1'b0;
        w_gap_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (get_byte) begin
                    w_start     = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_rise = w_tc && !r_sclk;
                w_fall = w_tc && r_sclk;
                w_last = w_fall && (r_bit == 3'd7);
                if (w_last) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                w_gap_done = (r_gap == GAP_LAST);
                if (w_gap_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= 8'd0;
            r_bit     <= 3'd0;
            r_gap     <= 16'd0;
            r_tx      <= 7'd0;
            r_rx      <= 8'd0;
            r_data_rx <= 8'd0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sclk <= 1'b0;
                    if (w_start) begin
                        r_tx   <= data_send[6:0];
                        r_mosi <= data_send[7];
                        r_busy <= 1'b1;
                        r_div  <= 8'd0;
                        r_bit  <= 3'd0;
                    end
                end
                SHIFT: begin
                    r_div <= w_tc ? 8'd0 : r_div + 8'd1;
                    if (w_tc) begin
                        r_sclk <= ~r_sclk;
                    end
                    if (w_rise) begin
                        r_rx <= {r_rx[6:0], miso};
                    end
                    // mosi only moves on the falling sclk edge; the last bit is held into the gap
                    if (w_fall) begin
                        r_bit <= r_bit + 3'd1;
                        if (!w_last) begin
                            r_mosi <= r_tx[6];
                            r_tx   <= {r_tx[5:0], 1'b0};
                        end
                    end
                    if (w_last) begin
                        r_data_rx <= r_rx;
                        r_gap     <= 16'd0;
                        if (GAP_CYCLES == 0) begin
                            r_busy <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    r_gap <= r_gap + 16'd1;
                    if (w_gap_done) begin
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_sclk <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign busy    = r_busy;
    assign data_rx = r_data_rx;

endmodule

// File: tb/tb_spi_mode0.sv
// Bench for spi_mode0: a mode-0 slave model and a transfer recorder per instance,
// with scenario tasks comparing recorded transfers against the expected byte flow.
module tb_spi_mode0;

    localparam int CLK_DIV = 2;
    localparam int GAP     = 4;
    localparam int BUSY_N  = 16 * CLK_DIV + GAP;
    localparam int BUSY0_N = 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       get_byte, miso, sclk, mosi, busy;
    logic [7:0] data_send, data_rx;
    logic       get_byte0, miso0, sclk0, mosi0, busy0;
    logic [7:0] data_send0, data_rx0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] mo;
        logic [7:0] rx;
        int         rises;
        int         bcnt;
    } rec_t;

    rec_t       recs[$];
    rec_t       recs0[$];
    logic [7:0] slv_q[$];
    logic [7:0] slv_q0[$];
    int         rises;
    int         last_low;

    spi_mode0 #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst(rst), .get_byte(get_byte), .data_send(data_send), .miso(miso),
        .sclk(sclk), .mosi(mosi), .busy(busy), .data_rx(data_rx)
    );

    spi_mode0 #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .get_byte(get_byte0), .data_send(data_send0), .miso(miso0),
        .sclk(sclk0), .mosi(mosi0), .busy(busy0), .data_rx(data_rx0)
    );

    always #5 clk = ~clk;

    // Slave + recorder for the gapped instance; everything observed on the falling clk edge.
    initial begin : mon
        bit         pb, ps;
        logic [7:0] sh, cap;
        int         bc, lc;
        pb = 0; ps = 0; sh = 0; cap = 0; bc = 0; lc = 0;
        rises = 0; last_low = 0; miso = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && !pb) begin
                last_low = lc;
                lc = 0;
                if (slv_q.size() > 0) sh = slv_q.pop_front();
                else sh = 8'h00;
                miso = sh[7];
                cap = 0; rises = 0; bc = 0;
            end else if (ps && sclk === 1'b0) begin
                sh = {sh[6:0], 1'b0};
                miso = sh[7];
            end
            if (sclk === 1'b1 && !ps) begin
                cap = {cap[6:0], mosi};
                rises++;
            end
            if (busy === 1'b1) bc++;
            else lc++;
            if (busy !== 1'b1 && pb) recs.push_back('{cap, data_rx, rises, bc});
            pb = (busy === 1'b1);
            ps = (sclk === 1'b1);
        end
    end

    initial begin : mon0
        bit         pb, ps;
        logic [7:0] sh, cap;
        int         bc, rc;
        pb = 0; ps = 0; sh = 0; cap = 0; bc = 0; rc = 0; miso0 = 1'b0;
        forever begin
            @(negedge clk);
            if (busy0 === 1'b1 && !pb) begin
                if (slv_q0.size() > 0) sh = slv_q0.pop_front();
                else sh = 8'h00;
                miso0 = sh[7];
                cap = 0; rc = 0; bc = 0;
            end else if (ps && sclk0 === 1'b0) begin
                sh = {sh[6:0], 1'b0};
                miso0 = sh[7];
            end
            if (sclk0 === 1'b1 && !ps) begin
                cap = {cap[6:0], mosi0};
                rc++;
            end
            if (busy0 === 1'b1) bc++;
            if (busy0 !== 1'b1 && pb) recs0.push_back('{cap, data_rx0, rc, bc});
            pb = (busy0 === 1'b1);
            ps = (sclk0 === 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] d);
        tick();
        data_send = d;
        get_byte  = 1'b1;
        tick();
        get_byte  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy !== 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        get_byte = 1'b0; data_send = 8'h00;
        get_byte0 = 1'b0; data_send0 = 8'h00;
        repeat (3) tick();
        total++;
        if ({sclk, mosi, busy, data_rx} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outs: got sclk=%b mosi=%b busy=%b rx=%h want all 0", sclk, mosi, busy, data_rx);
        end
        total++;
        if ({sclk0, mosi0, busy0, data_rx0} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outs0: got sclk=%b mosi=%b busy=%b rx=%h want all 0", sclk0, mosi0, busy0, data_rx0);
        end
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({sclk, busy} !== 2'b00) begin
            bad++;
            $display("FAIL idle_hold: got sclk=%b busy=%b want 0 0", sclk, busy);
        end
        recs.delete();
        recs0.delete();
    endtask

    task automatic test_single();
        bit ok;
        recs.delete();
        slv_q.push_back(8'h3C);
        start(8'hA5);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy_rise: got %b want 1", busy);
        end
        wait_idle(ok);
        total++;
        if (!ok || recs.size() != 1) begin
            bad++;
            $display("FAIL single_done: got ok=%0d records=%0d want 1 1", ok, recs.size());
        end else begin
            total++;
            if (recs[0].mo !== 8'hA5) begin
                bad++;
                $display("FAIL single_mosi: got %h want a5", recs[0].mo);
            end
            total++;
            if (recs[0].bcnt != BUSY_N) begin
                bad++;
                $display("FAIL single_busy_len: got %0d want %0d", recs[0].bcnt, BUSY_N);
            end
            total++;
            if (recs[0].rises != 8) begin
                bad++;
                $display("FAIL single_rises: got %0d want 8", recs[0].rises);
            end
            total++;
            if (recs[0].rx !== 8'h3C) begin
                bad++;
                $display("FAIL single_rx: got %h want 3c", recs[0].rx);
            end
        end
        total++;
        if (sclk !== 1'b0) begin
            bad++;
            $display("FAIL single_sclk_idle: got %b want 0", sclk);
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        logic [7:0] s1, s2;
        s1 = 8'($urandom);
        s2 = 8'($urandom);
        recs.delete();
        slv_q.push_back(s1);
        slv_q.push_back(s2);
        tick();
        data_send = 8'h01;
        get_byte  = 1'b1;
        tick();
        data_send = 8'h80;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy === 1'b0) begin ok = 1; break; end
        end
        for (int i = 0; i < 10 && ok; i++) begin
            tick();
            if (busy === 1'b1) break;
        end
        get_byte = 1'b0;
        if (ok) wait_idle(ok);
        total++;
        if (!ok || recs.size() != 2) begin
            bad++;
            $display("FAIL b2b_done: got ok=%0d records=%0d want 1 2", ok, recs.size());
        end else begin
            total++;
            if (recs[0].mo !== 8'h01 || recs[1].mo !== 8'h80) begin
                bad++;
                $display("FAIL b2b_mosi: got %h %h want 01 80", recs[0].mo, recs[1].mo);
            end
            total++;
            if (recs[0].rx !== s1 || recs[1].rx !== s2) begin
                bad++;
                $display("FAIL b2b_rx: got %h %h want %h %h", recs[0].rx, recs[1].rx, s1, s2);
            end
            total++;
            if (recs[0].rises != 8 || recs[1].rises != 8) begin
                bad++;
                $display("FAIL b2b_rises: got %0d %0d want 8 8", recs[0].rises, recs[1].rises);
            end
            total++;
            if (recs[0].bcnt != BUSY_N || recs[1].bcnt != BUSY_N) begin
                bad++;
                $display("FAIL b2b_busy_len: got %0d %0d want %0d", recs[0].bcnt, recs[1].bcnt, BUSY_N);
            end
            total++;
            if (last_low != 1) begin
                bad++;
                $display("FAIL b2b_gap_low: got %0d want 1", last_low);
            end
        end
    endtask

    task automatic test_ignored();
        bit         ok;
        logic [7:0] d, s;
        d = 8'($urandom_range(0, 254));
        s = 8'($urandom);
        recs.delete();
        slv_q.push_back(s);
        start(d);
        for (int i = 0; i < BUSY_N - 2; i++) begin
            tick();
            get_byte  = (i % 2 == 1);
            data_send = 8'hFF;
        end
        tick();
        get_byte = 1'b0;
        wait_idle(ok);
        repeat (5) tick();
        total++;
        if (!ok || busy !== 1'b0 || recs.size() != 1) begin
            bad++;
            $display("FAIL ign_done: got ok=%0d busy=%b records=%0d want 1 0 1", ok, busy, recs.size());
        end else begin
            total++;
            if (recs[0].mo !== d) begin
                bad++;
                $display("FAIL ign_mosi: got %h want %h", recs[0].mo, d);
            end
            total++;
            if (recs[0].rises != 8 || recs[0].bcnt != BUSY_N) begin
                bad++;
                $display("FAIL ign_shape: got rises=%0d busy=%0d want 8 %0d", recs[0].rises, recs[0].bcnt, BUSY_N);
            end
            total++;
            if (recs[0].rx !== s) begin
                bad++;
                $display("FAIL ign_rx: got %h want %h", recs[0].rx, s);
            end
        end
    endtask

    task automatic test_random();
        bit         ok;
        logic [7:0] d, s;
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom);
            s = 8'($urandom);
            recs.delete();
            slv_q.push_back(s);
            repeat ($urandom_range(0, 3)) tick();
            start(d);
            wait_idle(ok);
            total++;
            if (!ok || recs.size() != 1) begin
                bad++;
                $display("FAIL rand_done[%0d]: got ok=%0d records=%0d want 1 1", n, ok, recs.size());
            end else begin
                total++;
                if (recs[0].mo !== d || recs[0].rx !== s || data_rx !== s) begin
                    bad++;
                    $display("FAIL rand_data[%0d]: got mosi=%h rx=%h want %h %h", n, recs[0].mo, data_rx, d, s);
                end
                total++;
                if (recs[0].rises != 8 || recs[0].bcnt != BUSY_N) begin
                    bad++;
                    $display("FAIL rand_shape[%0d]: got rises=%0d busy=%0d want 8 %0d", n, recs[0].rises, recs[0].bcnt, BUSY_N);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        logic [7:0] d, s;
        slv_q.delete();
        slv_q.push_back(8'($urandom));
        start(8'h5A);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (rises >= 4) begin ok = 1; break; end
            tick();
        end
        total++;
        if (!ok || mosi !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: got ok=%0d mosi=%b want 1 1", ok, mosi);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({sclk, busy, mosi, data_rx} !== 11'h0) begin
            bad++;
            $display("FAIL rst_mid_outs: got sclk=%b busy=%b mosi=%b rx=%h want all 0", sclk, busy, mosi, data_rx);
        end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || data_rx !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_wait: got busy=%b rx=%h want 0 00", busy, data_rx);
        end
        recs.delete();
        recs0.delete();
        d = 8'($urandom);
        s = 8'($urandom);
        slv_q.push_back(s);
        start(d);
        wait_idle(ok);
        total++;
        if (!ok || recs.size() != 1) begin
            bad++;
            $display("FAIL rst_mid_after: got ok=%0d records=%0d want 1 1", ok, recs.size());
        end else begin
            total++;
            if (recs[0].mo !== d || recs[0].rx !== s || recs[0].rises != 8) begin
                bad++;
                $display("FAIL rst_mid_clean: got mosi=%h rx=%h rises=%0d want %h %h 8", recs[0].mo, recs[0].rx, recs[0].rises, d, s);
            end
        end
    endtask

    task automatic test_five_byte();
        bit          ok;
        logic [39:0] result;
        slv_q.delete();
        slv_q.push_back(8'h11);
        slv_q.push_back(8'h22);
        slv_q.push_back(8'h33);
        slv_q.push_back(8'h44);
        slv_q.push_back(8'h55);
        result = 40'h0;
        ok = 1;
        for (int n = 0; n < 5 && ok; n++) begin
            tick();
            data_send = 8'($urandom);
            get_byte  = 1'b1;
            ok = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (busy === 1'b1) begin ok = 1; break; end
            end
            get_byte = 1'b0;
            if (ok) wait_idle(ok);
            result = {result[31:0], data_rx};
        end
        total++;
        if (!ok || result !== 40'h1122334455) begin
            bad++;
            $display("FAIL five_byte: got ok=%0d result=%h want 1122334455", ok, result);
        end
    endtask

    task automatic test_gap0();
        bit         ok;
        logic [7:0] d, s;
        for (int n = 0; n < 2; n++) begin
            d = 8'($urandom);
            s = 8'($urandom);
            recs0.delete();
            slv_q0.push_back(s);
            tick();
            data_send0 = d;
            get_byte0  = 1'b1;
            tick();
            get_byte0  = 1'b0;
            ok = 0;
            for (int i = 0; i < 200; i++) begin
                if (busy0 !== 1'b1) begin ok = 1; break; end
                tick();
            end
            total++;
            if (!ok || data_rx0 !== s) begin
                bad++;
                $display("FAIL gap0_rx[%0d]: got ok=%0d rx=%h want 1 %h", n, ok, data_rx0, s);
            end
            total++;
            if (recs0.size() != 1) begin
                bad++;
                $display("FAIL gap0_records[%0d]: got %0d want 1", n, recs0.size());
            end else begin
                total++;
                if (recs0[0].bcnt != BUSY0_N || recs0[0].rises != 8 || recs0[0].mo !== d) begin
                    bad++;
                    $display("FAIL gap0_shape[%0d]: got busy=%0d rises=%0d mosi=%h want %0d 8 %h",
                             n, recs0[0].bcnt, recs0[0].rises, recs0[0].mo, BUSY0_N, d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored();
        test_random();
        test_reset_mid();
        test_five_byte();
        test_gap0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
